// File: rtl/redirect_ctrl_if.sv
// Bundle between the ID/fetch side and the redirect controller.
// ID decisions and fetch readiness flow in; next-PC select, flushes, stall and the counter flow out.
interface redirect_ctrl_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [6:0]           opcode;
    logic                 id_valid;
    logic                 operands_equal;
    logic [PC_WIDTH-1:0]  branch_target;
    logic [PC_WIDTH-1:0]  jump_target;
    logic                 fetch_ready;

    logic [1:0]           pc_src;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic                 flush_if;
    logic                 flush_id;
    logic                 stall_id;
    logic [CNT_WIDTH-1:0] redirect_count;

    modport master (
        output opcode, id_valid, operands_equal, branch_target, jump_target, fetch_ready,
        input  pc_src, redirect_pc, flush_if, flush_id, stall_id, redirect_count
    );

    modport slave (
        input  opcode, id_valid, operands_equal, branch_target, jump_target, fetch_ready,
        output pc_src, redirect_pc, flush_if, flush_id, stall_id, redirect_count
    );
endinterface

// File: rtl/redirect_ctrl.sv
// Resolves taken BEQ/JMP in ID, holds a pending redirect while fetch is busy,
// issues a one-cycle redirect with IF/ID squash and counts applied redirects (saturating).
module redirect_ctrl #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [6:0]  OP_BEQ    = 7'h63,
    parameter logic [6:0]  OP_JMP    = 7'h6F
) (
    input logic            clock,
    input logic            reset,
    redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT     = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    state_t               state_q, state_d;
    logic [1:0]           kind_q, kind_d;
    logic [PC_WIDTH-1:0]  target_q, target_d;

    logic [1:0]           pc_src_q, pc_src_d;
    logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
    logic                 flush_q, flush_d;
    logic                 stall_q, stall_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 take_branch_c;
    logic                 take_jump_c;

    assign take_branch_c = bus.id_valid && (bus.opcode == OP_BEQ) && bus.operands_equal;
    assign take_jump_c   = bus.id_valid && (bus.opcode == OP_JMP);

    // Next state, capture, and next registered outputs (outputs follow the next state).
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        target_d      = target_q;
        pc_src_d      = SRC_SEQ;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        stall_d       = 1'b0;
        count_d       = count_q;

        case (state_q)
            IDLE: begin
                if (take_jump_c) begin
                    kind_d   = SRC_JUMP;
                    target_d = bus.jump_target;
                    state_d  = bus.fetch_ready ? REDIRECT : WAIT;
                end else if (take_branch_c) begin
                    kind_d   = SRC_BRANCH;
                    target_d = bus.branch_target;
                    state_d  = bus.fetch_ready ? REDIRECT : WAIT;
                end
            end
            WAIT: begin
                if (bus.fetch_ready) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == REDIRECT) begin
            pc_src_d      = kind_d;
            redirect_pc_d = target_d;
            flush_d       = 1'b1;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end

        if (state_d == WAIT) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            kind_q        <= SRC_SEQ;
            target_q      <= '0;
            pc_src_q      <= SRC_SEQ;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            target_q      <= target_d;
            pc_src_q      <= pc_src_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            stall_q       <= stall_d;
            count_q       <= count_d;
        end
    end

    assign bus.pc_src         = pc_src_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if       = flush_q;
    assign bus.flush_id       = flush_q;
    assign bus.stall_id       = stall_q;
    assign bus.redirect_count = count_q;
endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences control-flow redirects from the decode stage into fetch. It resolves taken `OP_BEQ` and `OP_JMP` in ID, selects the next-PC source and target, and squashes wrong-path instructions in IF/ID. While fetch cannot accept a redirect, it holds the pending redirect and stalls ID. It also keeps a saturating count of applied redirects for performance monitoring.

## Interface
Parameters:
- `PC_WIDTH`, default 32: width of PC and target buses.
- `CNT_WIDTH`, default 16: width of the redirect counter.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  7: opcode of the instruction in ID. Compared against `OP_BEQ` and `OP_JMP` from `parameters.v`.
- `id_valid`  in  1: the ID instruction is valid, i.e. not a bubble.
- `operands_equal`  in  1: the BEQ comparison result for the ID instruction.
- `branch_target`  in  PC_WIDTH: BEQ target computed in ID.
- `jump_target`  in  PC_WIDTH: JMP target computed in ID.
- `fetch_ready`  in  1: fetch can accept a redirect this cycle.
- `pc_src`  out  2: next-PC select. 00 = PC+4, 01 = branch, 10 = jump. 11 is never driven.
- `redirect_pc`  out  PC_WIDTH: target for the active redirect.
- `flush_if`  out  1: squash the IF/ID register contents.
- `flush_id`  out  1: squash the ID/EX register contents for the wrong-path instruction.
- `stall_id`  out  1: freeze PC and IF/ID while a redirect is pending.
- `redirect_count`  out  CNT_WIDTH: number of redirects applied, saturating.

## Operation
- All outputs are registered. FSM states: IDLE, WAIT, REDIRECT.
- A redirect is "taken" when `id_valid` is 1 and either:
  - opcode == `OP_BEQ` and `operands_equal` is 1 (kind = branch, target = `branch_target`), or
  - opcode == `OP_JMP` (kind = jump, target = `jump_target`).
- BEQ with `operands_equal` = 0, any other opcode, or `id_valid` = 0 means no action.
- IDLE:
  - On a taken redirect, kind and target are captured.
  - If `fetch_ready` = 1, go to REDIRECT. Otherwise go to WAIT.
- WAIT:
  - `stall_id` = 1. ID inputs are ignored and the captured kind/target are held unchanged.
  - When `fetch_ready` = 1, go to REDIRECT. Otherwise stay.
- REDIRECT, lasting exactly one cycle:
  - `pc_src` = 01 (branch) or 10 (jump). `redirect_pc` = captured target.
  - `flush_if` = 1, `flush_id` = 1, `stall_id` = 0.
  - `redirect_count` increments, saturating at all-ones.
  - ID inputs are ignored, because the ID instruction is wrong-path.
  - Next state is always IDLE.
- Outside REDIRECT: `pc_src` = 00 and `flush_if` = `flush_id` = 0. `redirect_pc` holds its last value.
- Reset values: state IDLE, `pc_src` = 00, `redirect_pc` = 0, `flush_if` = `flush_id` = `stall_id` = 0, `redirect_count` = 0, captured kind/target cleared.
- Reset takes priority over every transition. Reset during WAIT or REDIRECT discards the pending redirect: no redirect is issued after reset and the counter is not incremented.

## Timing
- Decision in cycle N: IDLE, taken, `fetch_ready` = 1. REDIRECT outputs are visible in cycle N+1, for one cycle. Back to IDLE in cycle N+2, where a new decision can be made.
- Decision in cycle N with `fetch_ready` = 0:
  - `stall_id` = 1 from cycle N+1.
  - Let M be the first WAIT cycle with `fetch_ready` = 1. REDIRECT occurs in M+1, where `stall_id` drops to 0.
- `fetch_ready` is sampled only in IDLE (on a taken decision) and in WAIT. It is ignored in REDIRECT.
- Minimum spacing between two redirects is 2 cycles: REDIRECT then IDLE.
- Counter saturation: at all-ones, a further REDIRECT leaves the value unchanged. There is no wrap.
- No combinational path from any input to any output.

## Test plan
- Reset, then JMP with `jump_target` = 0x0000_0100, `id_valid` = 1, `fetch_ready` = 1 in cycle N -> cycle N+1: `pc_src` = 10, `redirect_pc` = 0x100, `flush_if` = `flush_id` = 1, `redirect_count` = 1. Cycle N+2: `pc_src` = 00, flushes = 0.
- BEQ with `operands_equal` = 0, then BEQ with `operands_equal` = 1 and `branch_target` = 0x40 -> the first produces no response. The second gives `pc_src` = 01, `redirect_pc` = 0x40 one cycle later. Repeat with `id_valid` = 0 -> no response.
- BEQ taken, target 0x80, `fetch_ready` = 0 for 3 cycles, and ID inputs change to a JMP to 0x200 during the wait -> `stall_id` = 1 for 3 cycles. Then `pc_src` = 01, `redirect_pc` = 0x80, `stall_id` = 0. The JMP is ignored.
- JMP in IDLE followed by a back-to-back JMP presented during the REDIRECT cycle -> the second JMP is ignored. A JMP presented in the following IDLE cycle is accepted, giving REDIRECT 2 cycles after the first.
- Reset asserted during WAIT, with `fetch_ready` rising in the same cycle -> next cycle all outputs at reset values. No redirect occurs and `redirect_count` = 0.
- Preload `redirect_count` to 0xFFFE via 0xFFFE redirects (or with `CNT_WIDTH` = 2 preload via 2 redirects), then apply 2 more -> value reaches all-ones and stays there.
